// File: rtl/edubos5_pkg.sv
// Shared types and constants for the edubos5 writeback stage.
package edubos5_pkg;

    typedef logic [31:0] cpu_data_t;

    typedef enum logic {
        WB_IDLE = 1'b0,
        WB_LOAD = 1'b1
    } wb_state_t;

    localparam logic [2:0] LD_B  = 3'b000;
    localparam logic [2:0] LD_H  = 3'b001;
    localparam logic [2:0] LD_W  = 3'b010;
    localparam logic [2:0] LD_BU = 3'b100;
    localparam logic [2:0] LD_HU = 3'b101;

endpackage

// File: rtl/edubos5_wb_ldext.sv
// Load data extraction: selects byte/halfword/word from the raw memory word,
// applies sign/zero extension and flags misaligned or illegal load types.
module edubos5_wb_ldext
    import edubos5_pkg::*;
(
    input  logic [2:0] funct3_i,
    input  logic [1:0] offset_i,
    input  cpu_data_t  word_i,
    output cpu_data_t  data_o,
    output logic       err_o
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    assign byte_s = word_i[{offset_i, 3'b000} +: 8];
    assign half_s = offset_i[1] ? word_i[31:16] : word_i[15:0];

    // Extraction and alignment check per load type
    always_comb begin
        data_o = 32'h0000_0000;
        err_o  = 1'b0;
        case (funct3_i)
            LD_B:  data_o = {{24{byte_s[7]}}, byte_s};
            LD_BU: data_o = {24'h00_0000, byte_s};
            LD_H: begin
                if (offset_i[0]) begin
                    err_o = 1'b1;
                end else begin
                    data_o = {{16{half_s[15]}}, half_s};
                end
            end
            LD_HU: begin
                if (offset_i[0]) begin
                    err_o = 1'b1;
                end else begin
                    data_o = {16'h0000, half_s};
                end
            end
            LD_W: begin
                if (offset_i != 2'b00) begin
                    err_o = 1'b1;
                end else begin
                    data_o = word_i;
                end
            end
            default: err_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/edubos5_wb.sv
// Writeback stage: retires ALU results and completes loads into the RF.
// Define EDUBOS5_WB_BYPASS_EN to forward the pending RF write onto rs1/rs2.
module edubos5_wb
    import edubos5_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ex_valid,
    output logic       ex_ready,
    input  logic       ex_is_load,
    input  logic [4:0] ex_rd,
    input  cpu_data_t  ex_data,
    input  logic [2:0] ex_funct3,
    input  logic [1:0] ex_addr_lo,
    input  logic       dmem_rvalid,
    input  cpu_data_t  dmem_rdata,
    output logic [4:0] rf_addr,
    output logic       rf_we,
    output cpu_data_t  rf_wdat,
    input  logic [4:0] rs1_addr,
    input  logic [4:0] rs2_addr,
    input  cpu_data_t  rf_rs1,
    input  cpu_data_t  rf_rs2,
    output cpu_data_t  rs1,
    output cpu_data_t  rs2,
    output logic       load_err
);

    wb_state_t  state_q, state_d;
    logic       ready_q, ready_d;
    logic       we_q, we_d;
    logic [4:0] addr_q, addr_d;
    cpu_data_t  wdat_q, wdat_d;
    logic       err_q, err_d;
    logic [4:0] ld_rd_q, ld_rd_d;
    logic [2:0] ld_f3_q, ld_f3_d;
    logic [1:0] ld_off_q, ld_off_d;
    cpu_data_t  ext_data_s;
    logic       ext_err_s;

    edubos5_wb_ldext u_ldext (
        .funct3_i (ld_f3_q),
        .offset_i (ld_off_q),
        .word_i   (dmem_rdata),
        .data_o   (ext_data_s),
        .err_o    (ext_err_s)
    );

    // Next-state and registered-output computation
    always_comb begin
        state_d  = state_q;
        we_d     = 1'b0;
        addr_d   = addr_q;
        wdat_d   = wdat_q;
        err_d    = 1'b0;
        ld_rd_d  = ld_rd_q;
        ld_f3_d  = ld_f3_q;
        ld_off_d = ld_off_q;
        case (state_q)
            WB_IDLE: begin
                if (ex_valid && ready_q) begin
                    if (ex_is_load) begin
                        ld_rd_d  = ex_rd;
                        ld_f3_d  = ex_funct3;
                        ld_off_d = ex_addr_lo;
                        state_d  = WB_LOAD;
                    end else if (ex_rd != 5'd0) begin
                        we_d   = 1'b1;
                        addr_d = ex_rd;
                        wdat_d = ex_data;
                    end else begin
                        we_d = 1'b0;
                    end
                end else begin
                    state_d = WB_IDLE;
                end
            end
            WB_LOAD: begin
                if (dmem_rvalid) begin
                    state_d = WB_IDLE;
                    if (ext_err_s) begin
                        err_d = 1'b1;
                    end else if (ld_rd_q != 5'd0) begin
                        we_d   = 1'b1;
                        addr_d = ld_rd_q;
                        wdat_d = ext_data_s;
                    end else begin
                        we_d = 1'b0;
                    end
                end else begin
                    state_d = WB_LOAD;
                end
            end
            default: state_d = WB_IDLE;
        endcase
        ready_d = (state_d == WB_IDLE);
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= WB_IDLE;
            ready_q  <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= 5'd0;
            wdat_q   <= 32'h0000_0000;
            err_q    <= 1'b0;
            ld_rd_q  <= 5'd0;
            ld_f3_q  <= 3'd0;
            ld_off_q <= 2'd0;
        end else begin
            state_q  <= state_d;
            ready_q  <= ready_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdat_q   <= wdat_d;
            err_q    <= err_d;
            ld_rd_q  <= ld_rd_d;
            ld_f3_q  <= ld_f3_d;
            ld_off_q <= ld_off_d;
        end
    end

    assign ex_ready = ready_q;
    assign rf_we    = we_q;
    assign rf_addr  = addr_q;
    assign rf_wdat  = wdat_q;
    assign load_err = err_q;

`ifdef EDUBOS5_WB_BYPASS_EN
    assign rs1 = (we_q && (addr_q == rs1_addr) && (rs1_addr != 5'd0)) ? wdat_q : rf_rs1;
    assign rs2 = (we_q && (addr_q == rs2_addr) && (rs2_addr != 5'd0)) ? wdat_q : rf_rs2;
`else
    assign rs1 = rf_rs1;
    assign rs2 = rf_rs2;
`endif

endmodule

// File: tb/tb_edubos5_wb.sv
// Self-checking bench for edubos5_wb using a behavioural writeback model.
module tb_edubos5_wb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid, ex_ready, ex_is_load;
    logic [4:0]  ex_rd;
    logic [31:0] ex_data;
    logic [2:0]  ex_funct3;
    logic [1:0]  ex_addr_lo;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic [4:0]  rf_addr;
    logic        rf_we;
    logic [31:0] rf_wdat;
    logic [4:0]  rs1_addr, rs2_addr;
    logic [31:0] rf_rs1, rf_rs2, rs1, rs2;
    logic        load_err;

    int checks = 0;
    int failures = 0;

    logic [4:0]  exp_addr;
    logic [31:0] exp_wdat;

`ifdef EDUBOS5_WB_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    edubos5_wb dut (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_is_load(ex_is_load), .ex_rd(ex_rd), .ex_data(ex_data),
        .ex_funct3(ex_funct3), .ex_addr_lo(ex_addr_lo),
        .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .rf_addr(rf_addr), .rf_we(rf_we), .rf_wdat(rf_wdat),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rf_rs1(rf_rs1), .rf_rs2(rf_rs2),
        .rs1(rs1), .rs2(rs2), .load_err(load_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference load result from the architectural rules, plain arithmetic
    function automatic void model_ld(input logic [2:0] f3, input logic [1:0] off,
                                     input logic [31:0] w, output logic [31:0] d,
                                     output logic e);
        int unsigned b, h;
        b = (w >> (8 * off)) & 32'd255;
        h = (w >> (16 * (off / 2))) & 32'd65535;
        e = 1'b0;
        d = 32'd0;
        case (f3)
            3'd0: d = (b >= 128) ? (b + 32'hFFFF_FF00) : b;
            3'd4: d = b;
            3'd1: if (off % 2 == 1) e = 1'b1; else d = (h >= 32768) ? (h + 32'hFFFF_0000) : h;
            3'd5: if (off % 2 == 1) e = 1'b1; else d = h;
            3'd2: if (off != 0) e = 1'b1; else d = w;
            default: e = 1'b1;
        endcase
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) step();
        checks++; if (ex_ready !== 1'b0) begin failures++; $display("FAIL rst_ready got=%0b exp=0", ex_ready); end
        checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL rst_we got=%0b exp=0", rf_we); end
        checks++; if (rf_addr !== 5'd0) begin failures++; $display("FAIL rst_addr got=%0d exp=0", rf_addr); end
        checks++; if (rf_wdat !== 32'd0) begin failures++; $display("FAIL rst_wdat got=%h exp=0", rf_wdat); end
        checks++; if (load_err !== 1'b0) begin failures++; $display("FAIL rst_err got=%0b exp=0", load_err); end
        exp_addr = 5'd0;
        exp_wdat = 32'd0;
        rst_n = 1'b1;
        step();
        checks++; if (ex_ready !== 1'b1) begin failures++; $display("FAIL rel_ready got=%0b exp=1", ex_ready); end
    endtask

    // One ALU transfer plus operand lookup; checks write port and bypass outputs
    task automatic alu_xfer(input logic [4:0] rd, input logic [31:0] data,
                            input logic [4:0] a1, input logic [4:0] a2, string tag);
        logic [31:0] r1, r2, e1, e2;
        logic ew;
        r1 = $urandom; r2 = $urandom;
        ex_valid = 1'b1; ex_is_load = 1'b0; ex_rd = rd; ex_data = data;
        rs1_addr = a1; rs2_addr = a2; rf_rs1 = r1; rf_rs2 = r2;
        step();
        ew = (rd != 5'd0);
        if (ew) begin exp_addr = rd; exp_wdat = data; end
        e1 = (BYPASS && ew && a1 == rd && a1 != 5'd0) ? data : r1;
        e2 = (BYPASS && ew && a2 == rd && a2 != 5'd0) ? data : r2;
        checks++; if (rf_we !== ew) begin failures++; $display("FAIL %s_we got=%0b exp=%0b", tag, rf_we, ew); end
        checks++; if (rf_addr !== exp_addr || rf_wdat !== exp_wdat) begin failures++;
            $display("FAIL %s_wr got=%0d/%h exp=%0d/%h", tag, rf_addr, rf_wdat, exp_addr, exp_wdat); end
        checks++; if (rs1 !== e1 || rs2 !== e2) begin failures++;
            $display("FAIL %s_byp got=%h/%h exp=%h/%h", tag, rs1, rs2, e1, e2); end
        checks++; if (ex_ready !== 1'b1) begin failures++; $display("FAIL %s_ready got=%0b exp=1", tag, ex_ready); end
    endtask

    task automatic test_alu();
        alu_xfer(5'd5, 32'hDEAD_BEEF, 5'd1, 5'd2, "alu");
        alu_xfer(5'd0, 32'h0000_0001, 5'd0, 5'd0, "alu_rd0");
        ex_valid = 1'b0;
        step();
        checks++; if (rf_we !== 1'b0 || rf_wdat !== 32'hDEAD_BEEF || rf_addr !== 5'd5) begin failures++;
            $display("FAIL alu_hold got=%0b/%0d/%h exp=0/5/deadbeef", rf_we, rf_addr, rf_wdat); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 24; i++) begin
            logic [4:0] rd;
            rd = 5'($urandom_range(0, 31));
            alu_xfer(rd, $urandom, ($urandom_range(0, 1) == 1) ? rd : 5'($urandom), 5'($urandom), "b2b");
        end
        ex_valid = 1'b0;
        step();
    endtask

    // Full load transaction with garbage ex traffic while the stage is busy
    task automatic do_load(input logic [2:0] f3, input logic [1:0] off, input logic [4:0] rd,
                           input logic [31:0] word, input int dly, string tag);
        logic [31:0] d;
        logic e, ew;
        model_ld(f3, off, word, d, e);
        ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = rd; ex_funct3 = f3; ex_addr_lo = off;
        ex_data = $urandom; dmem_rvalid = 1'b0;
        step();
        checks++; if (rf_we !== 1'b0 || ex_ready !== 1'b0) begin failures++;
            $display("FAIL %s_acc we=%0b ready=%0b exp=0/0", tag, rf_we, ex_ready); end
        ex_is_load = 1'b0; ex_rd = 5'($urandom_range(1, 31)); ex_data = $urandom;
        for (int i = 0; i < dly; i++) begin
            step();
            checks++; if (rf_we !== 1'b0 || ex_ready !== 1'b0 || load_err !== 1'b0) begin failures++;
                $display("FAIL %s_wait we=%0b ready=%0b err=%0b exp=0/0/0", tag, rf_we, ex_ready, load_err); end
        end
        dmem_rvalid = 1'b1; dmem_rdata = word;
        step();
        ex_valid = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = $urandom;
        ew = !e && (rd != 5'd0);
        if (ew) begin exp_addr = rd; exp_wdat = d; end
        checks++; if (rf_we !== ew || load_err !== e) begin failures++;
            $display("FAIL %s_done we=%0b err=%0b exp=%0b/%0b", tag, rf_we, load_err, ew, e); end
        checks++; if (rf_addr !== exp_addr || rf_wdat !== exp_wdat) begin failures++;
            $display("FAIL %s_data got=%0d/%h exp=%0d/%h", tag, rf_addr, rf_wdat, exp_addr, exp_wdat); end
        step();
        checks++; if (ex_ready !== 1'b1 || rf_we !== 1'b0 || load_err !== 1'b0) begin failures++;
            $display("FAIL %s_post ready=%0b we=%0b err=%0b exp=1/0/0", tag, ex_ready, rf_we, load_err); end
    endtask

    task automatic test_load();
        do_load(3'b000, 2'd2, 5'd3, 32'h12F4_5678, 4, "lb");
        checks++; if (rf_wdat !== 32'hFFFF_FFF4) begin failures++; $display("FAIL lb_const got=%h exp=fffffff4", rf_wdat); end
        do_load(3'b100, 2'd2, 5'd3, 32'h12F4_5678, 4, "lbu");
        checks++; if (rf_wdat !== 32'h0000_00F4) begin failures++; $display("FAIL lbu_const got=%h exp=000000f4", rf_wdat); end
        do_load(3'b001, 2'd1, 5'd9, 32'h8765_4321, 2, "lh_mis");
        do_load(3'b010, 2'd0, 5'd0, 32'hCAFE_F00D, 1, "ld_rd0");
        do_load(3'b110, 2'd0, 5'd4, 32'h1111_2222, 0, "ld_ill");
        for (int i = 0; i < 40; i++)
            do_load(3'($urandom), 2'($urandom), 5'($urandom), $urandom, $urandom_range(0, 3), "ld_rnd");
    endtask

    task automatic test_idle_rvalid();
        ex_valid = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = $urandom;
        step();
        dmem_rvalid = 1'b0;
        checks++; if (rf_we !== 1'b0 || load_err !== 1'b0 || ex_ready !== 1'b1) begin failures++;
            $display("FAIL idle_rv we=%0b err=%0b ready=%0b exp=0/0/1", rf_we, load_err, ex_ready); end
    endtask

    task automatic test_reset_in_load();
        ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd12; ex_funct3 = 3'b010; ex_addr_lo = 2'd0;
        step();
        ex_valid = 1'b0;
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        exp_addr = 5'd0; exp_wdat = 32'd0;
        step();
        dmem_rvalid = 1'b1; dmem_rdata = 32'h5555_AAAA;
        step();
        dmem_rvalid = 1'b0;
        checks++; if (rf_we !== 1'b0 || load_err !== 1'b0 || ex_ready !== 1'b1) begin failures++;
            $display("FAIL rst_load we=%0b err=%0b ready=%0b exp=0/0/1", rf_we, load_err, ex_ready); end
        checks++; if (rf_addr !== exp_addr || rf_wdat !== exp_wdat) begin failures++;
            $display("FAIL rst_load_data got=%0d/%h exp=0/0", rf_addr, rf_wdat); end
    endtask

    task automatic test_bypass();
        logic [31:0] r2, e1;
        r2 = $urandom;
        ex_valid = 1'b1; ex_is_load = 1'b0; ex_rd = 5'd7; ex_data = 32'hA5A5_A5A5;
        rs1_addr = 5'd7; rf_rs1 = 32'd0; rs2_addr = 5'd0; rf_rs2 = r2;
        step();
        ex_valid = 1'b0;
        exp_addr = 5'd7; exp_wdat = 32'hA5A5_A5A5;
        e1 = BYPASS ? 32'hA5A5_A5A5 : 32'd0;
        #1;
        checks++; if (rs1 !== e1) begin failures++; $display("FAIL byp_rs1 got=%h exp=%h", rs1, e1); end
        checks++; if (rs2 !== r2) begin failures++; $display("FAIL byp_rs2_x0 got=%h exp=%h", rs2, r2); end
        step();
        checks++; if (rs1 !== 32'd0) begin failures++; $display("FAIL byp_idle got=%h exp=0", rs1); end
    endtask

    initial begin
        rst_n = 1'b0; ex_valid = 1'b0; ex_is_load = 1'b0; ex_rd = 5'd0; ex_data = 32'd0;
        ex_funct3 = 3'd0; ex_addr_lo = 2'd0; dmem_rvalid = 1'b0; dmem_rdata = 32'd0;
        rs1_addr = 5'd0; rs2_addr = 5'd0; rf_rs1 = 32'd0; rf_rs2 = 32'd0;
        exp_addr = 5'd0; exp_wdat = 32'd0;
        test_reset();
        test_alu();
        test_back_to_back();
        test_load();
        test_idle_rvalid();
        test_reset_in_load();
        test_bypass();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
